// File: rtl/booth_mul_sequencer_if.sv
// Handshake, result and shared-adder bundle for the Booth MUL sequencer.
// The slave side is the sequencer; the master side is the ALU/adder.
interface booth_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;

  modport master (
    output start, multiplicand, multiplier, add_s,
    input  busy, done, hi, lo, add_a, add_b, add_cin
  );

  modport slave (
    input  start, multiplicand, multiplier, add_s,
    output busy, done, hi, lo, add_a, add_b, add_cin
  );
endinterface

// File: rtl/booth_mul_sequencer.sv
// Radix-2 Booth signed multiplier controller driving a shared
// external combinational adder, one step per clock; result in hi/lo.
module booth_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic reset_n,
  booth_mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, q, m;
  logic [WIDTH-1:0] hi, lo;
  logic             q_m1;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_op, b_op, sum;
  logic             cin, ovf, sbit, last;

  assign sum  = bus.add_s;
  assign last = (count == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    a_op      = '0;
    b_op      = '0;
    cin       = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        a_op = acc;
        unique case ({q[0], q_m1})
          2'b01: b_op = m;
          2'b10: begin
            b_op = ~m;
            cin  = 1'b1;
          end
          default: ;
        endcase
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Recover the true sign when ACC +/- M overflows (needed for M = min int)
  assign ovf  = (a_op[WIDTH-1] == b_op[WIDTH-1])
             && (sum[WIDTH-1] != a_op[WIDTH-1]);
  assign sbit = ovf ? ~sum[WIDTH-1] : sum[WIDTH-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      m     <= '0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (bus.start) begin
          acc   <= '0;
          q     <= bus.multiplier;
          q_m1  <= 1'b0;
          m     <= bus.multiplicand;
          count <= '0;
        end
        RUN: begin
          acc   <= {sbit, sum[WIDTH-1:1]};
          q     <= {sum[0], q[WIDTH-1:1]};
          q_m1  <= q[0];
          count <= count + 1'b1;
          if (last) begin
            hi <= {sbit, sum[WIDTH-1:1]};
            lo <= {sum[0], q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.hi      = hi;
  assign bus.lo      = lo;
  assign bus.add_a   = a_op;
  assign bus.add_b   = b_op;
  assign bus.add_cin = cin;
endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Directed plus random bench for booth_mul_sequencer with a
// behavioural adder and a plain-arithmetic signed product reference.
module tb_booth_mul_sequencer;
  logic clock;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  booth_mul_sequencer_if #(.WIDTH(32)) bus ();

  booth_mul_sequencer #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.add_s = bus.add_a + bus.add_b + 32'(bus.add_cin);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_op(logic [31:0] a, logic [31:0] b);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    step(1);
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done(string tag, logic [63:0] exp, int cyc);
    int n = 0;
    while (bus.busy && n < 40) begin
      n++;
      step(1);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(cyc));
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_product"}, {bus.hi, bus.lo}, exp);
    step(1);
    check({tag, "_done_clear"}, 64'(bus.done), 64'd0);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    step(2);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_add_b", 64'(bus.add_b), 64'd0);
    reset_n = 1'b1;
    step(1);

    start_op(32'd6, 32'd7);
    wait_done("m6q7", 64'h0000_0000_0000_002A, 32);

    start_op(32'hFFFF_FFFD, 32'd5);
    wait_done("neg3x5", 64'hFFFF_FFFF_FFFF_FFF1, 32);

    start_op(32'h8000_0000, 32'h8000_0000);
    wait_done("min_min", 64'h4000_0000_0000_0000, 32);

    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("min_neg1", 64'h0000_0000_8000_0000, 32);

    start_op(32'h1234_5678, 32'd1);
    check("s1_add_a", 64'(bus.add_a), 64'd0);
    check("s1_add_b", 64'(bus.add_b), 64'h0000_0000_EDCB_A987);
    check("s1_cin", 64'(bus.add_cin), 64'd1);
    step(1);
    check("s2_add_b", 64'(bus.add_b), 64'h0000_0000_1234_5678);
    check("s2_cin", 64'(bus.add_cin), 64'd0);
    wait_done("m1234", 64'h0000_0000_1234_5678, 31);

    start_op(32'd2, 32'd3);
    step(9);
    bus.start        = 1'b1;
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    wait_done("ignored", 64'd6, 23);
    step(1);
    check("restart_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    check("hold_lo", 64'(bus.lo), 64'd6);
    wait_done("m9q9", 64'd81, 32);

    start_op(32'd6, 32'd7);
    step(14);
    reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("arst_add", {bus.add_a, bus.add_b}, 64'd0);
    check("arst_cin", 64'(bus.add_cin), 64'd0);
    #2;
    reset_n = 1'b1;
    step(1);
    start_op(32'd6, 32'd7);
    wait_done("after_rst", 64'd42, 32);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h7FFF_FFFF;
      if (i == 1) rb = 32'h8000_0000;
      if (i == 2) ra = 32'd0;
      start_op(ra, rb);
      wait_done("rand", ref_mul(ra, rb), 32);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
